// File: rtl/nn_sequencer.sv
// Programmable instruction sequencer feeding the nn datapath instruction port.
// Latency: first entry on instruction one cycle after accepted start; done one cycle after last issue.
// Backpressure: none; program writes are dropped while running, start is ignored while running.
module nn_sequencer #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata,
    input  logic [AW:0]   prog_len,
    input  logic [7:0]    loop_count,
    input  logic          start,
    input  logic          abort,
    output logic [23:0]   instruction,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [DEPTH];
    logic [7:0]    hold, hold_nxt;
    logic [7:0]    passes, passes_nxt;
    logic [AW-1:0] len_m1, len_m1_nxt;
    logic [23:0]   instr_nxt;
    logic          busy_nxt, done_nxt, err_nxt;
    logic [AW-1:0] pc_nxt;

    logic          wr_en;
    logic [31:0]   entry0;
    logic [31:0]   entry_next;
    logic          len_ok;

    assign wr_en = prog_we && (state == IDLE || state == DONE);

    // A write to entry 0 coinciding with start must be the value issued first.
    assign entry0     = (wr_en && prog_addr == '0) ? prog_wdata : mem[0];
    assign entry_next = mem[pc + AW'(1)];
    assign len_ok     = (prog_len != '0) && (prog_len <= (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            instruction <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            pc          <= '0;
            hold        <= '0;
            passes      <= '0;
            len_m1      <= '0;
        end else begin
            state       <= state_nxt;
            instruction <= instr_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
            pc          <= pc_nxt;
            hold        <= hold_nxt;
            passes      <= passes_nxt;
            len_m1      <= len_m1_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        instr_nxt  = instruction;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        pc_nxt     = pc;
        hold_nxt   = hold;
        passes_nxt = passes;
        len_m1_nxt = len_m1;

        if (abort) begin
            state_nxt = IDLE;
            instr_nxt = '0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state_nxt = IDLE;
                    instr_nxt = '0;
                    busy_nxt  = 1'b0;
                    if (start) begin
                        if (len_ok) begin
                            state_nxt  = RUN;
                            busy_nxt   = 1'b1;
                            pc_nxt     = '0;
                            instr_nxt  = entry0[23:0];
                            hold_nxt   = entry0[31:24];
                            passes_nxt = (loop_count == 8'd0) ? 8'd1 : loop_count;
                            len_m1_nxt = AW'(prog_len - 1'b1);
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hold != 8'd0) begin
                        hold_nxt = hold - 8'd1;
                    end else if (pc != len_m1) begin
                        pc_nxt    = pc + AW'(1);
                        instr_nxt = entry_next[23:0];
                        hold_nxt  = entry_next[31:24];
                    end else if (passes > 8'd1) begin
                        // Wrap straight into entry 0 so passes run back-to-back.
                        passes_nxt = passes - 8'd1;
                        pc_nxt     = '0;
                        instr_nxt  = mem[0][23:0];
                        hold_nxt   = mem[0][31:24];
                    end else begin
                        state_nxt = DONE;
                        instr_nxt = '0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    instr_nxt = '0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_sequencer.sv
// Scoreboard bench for nn_sequencer: stimulus queues expected events, a negedge monitor checks them.
module tb_nn_sequencer;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   prog_wdata = '0;
    logic [AW:0]   prog_len = '0;
    logic [7:0]    loop_count = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [23:0]   instruction;
    logic          busy, done, err;
    logic [AW-1:0] pc;

    nn_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_len(prog_len), .loop_count(loop_count),
        .start(start), .abort(abort), .instruction(instruction), .busy(busy),
        .done(done), .err(err), .pc(pc)
    );

    always #5 clk = ~clk;

    // kind: 0 issue cycle, 1 done pulse, 2 err pulse
    typedef struct {
        int          kind;
        logic [23:0] ins;
        logic [AW-1:0] pc;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  drain_seq = 0;
    int  drain_seen = 0;
    int  drain_left = 0;

    always @(negedge clk) begin
        ev_t exp;
        int  act_kind;
        if (!rst) begin
            checks++;
            if (instruction != 24'd0 || busy || done || err || pc != '0) begin
                errors++;
                $display("FAIL reset_state: instr=%h busy=%b done=%b err=%b pc=%0d, required all zero",
                         instruction, busy, done, err, pc);
            end
        end else begin
            if (!busy) begin
                checks++;
                if (instruction != 24'd0) begin
                    errors++;
                    $display("FAIL idle_instr: instr=%h while not busy, required 000000", instruction);
                end
            end
            if (busy || done || err) begin
                act_kind = busy ? 0 : (done ? 1 : 2);
                checks++;
                if (int'(busy) + int'(done) + int'(err) > 1) begin
                    errors++;
                    $display("FAIL flags_exclusive: busy=%b done=%b err=%b, required at most one",
                             busy, done, err);
                end else if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: kind=%0d instr=%h pc=%0d, required no event",
                             act_kind, instruction, pc);
                end else begin
                    exp = q.pop_front();
                    if (act_kind != exp.kind ||
                        (exp.kind == 0 && (instruction != exp.ins || pc != exp.pc)) ||
                        (exp.kind == 1 && pc != exp.pc)) begin
                        errors++;
                        $display("FAIL event: got kind=%0d instr=%h pc=%0d, required kind=%0d instr=%h pc=%0d",
                                 act_kind, instruction, pc, exp.kind, exp.ins, exp.pc);
                    end
                end
            end
        end
        if (drain_seq != drain_seen) begin
            drain_seen = drain_seq;
            checks++;
            if (drain_left != 0) begin
                errors++;
                $display("FAIL drain_timeout: %0d expected events never seen, required 0", drain_left);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        prog_we    = 1'b1;
        prog_addr  = AW'(a);
        prog_wdata = d;
        cyc();
        prog_we    = 1'b0;
    endtask

    task automatic run(input int len, input int lc);
        prog_len   = (AW+1)'(len);
        loop_count = 8'(lc);
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    task automatic push(input int kind, input logic [23:0] ins, input int p);
        ev_t e;
        e.kind = kind;
        e.ins  = ins;
        e.pc   = AW'(p);
        q.push_back(e);
    endtask

    // Expected stream for the two-entry program: entry0 H=0, entry1 hold h1.
    task automatic push_basic(input int passes, input int h1);
        for (int p = 0; p < passes; p++) begin
            push(0, 24'h000001, 0);
            for (int i = 0; i <= h1; i++) push(0, 24'h00ABCD, 1);
        end
        push(1, 24'h0, 1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) cyc();
        drain_left = q.size();
        drain_seq++;
        q.delete();
        cyc();
        cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        rst = 1'b1;
        cyc();

        wr(0, {8'd0, 24'h000001});
        wr(1, {8'd2, 24'h00ABCD});

        // Basic run, then loops of 3 and loop_count 0 (treated as 1)
        push_basic(1, 2); run(2, 1); drain(20);
        push_basic(3, 2); run(2, 3); drain(40);
        push_basic(1, 2); run(2, 0); drain(20);

        // Abort at cycle 3 with H1=9, restart at cycle 6
        wr(1, {8'd9, 24'h00ABCD});
        push(0, 24'h000001, 0); push(0, 24'h00ABCD, 1); push(0, 24'h00ABCD, 1);
        run(2, 1);
        cyc(); cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc(); cyc();
        push_basic(1, 9); run(2, 1); drain(40);
        wr(1, {8'd2, 24'h00ABCD});

        // Write during RUN must be dropped
        push_basic(1, 2); run(2, 1);
        wr(1, 32'h00FFFFFF);
        drain(20);
        push_basic(1, 2); run(2, 1); drain(20);

        // Illegal lengths
        push(2, 24'h0, 0); run(0, 1); drain(10);
        push(2, 24'h0, 0); run(DEPTH + 1, 1); drain(10);

        // Start together with abort: nothing happens
        abort = 1'b1; run(2, 1); abort = 1'b0;
        repeat (4) cyc();

        // Write to entry 0 in the start cycle is issued
        push(0, 24'h000055, 0); push(1, 24'h0, 0);
        prog_we = 1'b1; prog_addr = '0; prog_wdata = {8'd0, 24'h000055};
        run(1, 1);
        prog_we = 1'b0;
        drain(10);

        // Maximum hold: H=255 gives 256 issue cycles
        wr(0, {8'd255, 24'h0000AA});
        for (int i = 0; i < 256; i++) push(0, 24'h0000AA, 0);
        push(1, 24'h0, 0);
        run(1, 1); drain(300);

        // Asynchronous reset during cycle 3 of the basic run
        wr(0, {8'd0, 24'h000001});
        push(0, 24'h000001, 0); push(0, 24'h00ABCD, 1);
        run(2, 1);
        cyc(); cyc();
        #1 rst = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        repeat (5) cyc();
        drain(2);

        // Full depth, H=0, mem[k]=k
        for (int k = 0; k < DEPTH; k++) wr(k, {8'd0, 24'(k)});
        for (int k = 0; k < DEPTH; k++) push(0, 24'(k), k);
        push(1, 24'h0, DEPTH - 1);
        run(DEPTH, 1); drain(100);

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_sequencer.md
Name: nn_sequencer

Overview:
- Programmable instruction sequencer that drives the 24-bit `instruction` input of the nn datapath.
- A host preloads a small program of instruction entries, each with a hold count, then pulses `start`.
- The block issues the entries back-to-back, each for a programmed number of cycles. It optionally repeats the whole program, and reports busy/done/error status.
- It replaces hand-driven instruction streams in benches and is the first step toward a layer scheduler.

Parameters:
- DEPTH, 64, number of program entries (power of two, 2..256)
- AW, $clog2(DEPTH), program address width (derived; do not override)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- prog_we  input  1  program write strobe
- prog_addr  input  AW  program write address
- prog_wdata  input  32  entry: [23:0] instruction payload, [31:24] hold count H (issued for H+1 cycles)
- prog_len  input  AW+1  number of entries to run; sampled on accepted start
- loop_count  input  8  number of program passes; 0 treated as 1; sampled on accepted start
- start  input  1  run request, single-cycle pulse or level
- abort  input  1  terminate run
- instruction  output  24  to nn instruction port; registered
- busy  output  1  high while an entry is being issued
- done  output  1  one-cycle pulse after normal completion
- err  output  1  one-cycle pulse on rejected start
- pc  output  AW  index of entry currently on `instruction`; registered

Behaviour:
- Reset (rst=0, asynchronous): instruction=0, busy=0, done=0, err=0, pc=0, state IDLE; hold/pass counters cleared.
- Program memory: DEPTH x 32 register array with combinational read. It is not reset (contents undefined until written).
- Memory writes: prog_we takes effect at the clock edge only when the block is in IDLE or DONE. When busy, prog_we is dropped silently.
- States: IDLE, RUN, DONE.
- IDLE: instruction=0, busy=0.
  - start=1 with abort=0 and 1<=prog_len<=DEPTH: latch len and passes (loop_count, 0->1), then go to RUN. At the same edge: pc=0, instruction=mem[0][23:0], hold=mem[0][31:24].
  - start=1 with prog_len=0 or prog_len>DEPTH: err=1 for the next cycle; stay in IDLE.
  - A write to addr 0 in the same cycle as start is visible, i.e. the new value is issued.
- RUN: busy=1.
  - Each cycle with hold!=0: hold decrements; instruction and pc are unchanged.
  - When hold==0, advance at the next edge:
    - If pc<len-1: pc+1, and load that entry.
    - Else if passes remaining>1: decrement passes, pc=0, load entry 0. There is no bubble across the wrap.
    - Else: go to DONE with instruction=0.
  - start is ignored in RUN.
- DONE: exactly one cycle; done=1, busy=0, instruction=0, pc holds its last value. Then go to IDLE. A start sampled in DONE is accepted exactly as in IDLE.
- Latency:
  - start sampled at edge T puts the first entry on `instruction` from cycle T+1.
  - Total issue cycles = passes x sum(H_k+1).
  - done is asserted the cycle after the last issue cycle.
- abort=1 (any state, priority over start): at the next edge go to IDLE with instruction=0, busy=0. No done pulse; pc holds its value.
- Simultaneous start and abort in IDLE: abort wins; there is no run and no err.
- Counters:
  - hold is 8-bit; H=255 gives 256 cycles.
  - The pass counter is 8-bit, so 255 passes is the maximum.
  - pc wraps only via the pass logic, never past len-1.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Basic run: write mem[0]={8'd0,24'h000001}, mem[1]={8'd2,24'h00ABCD}; prog_len=2, loop_count=1; start at cycle 0.
  - Required: instruction=0x000001 at cycle 1 and 0x00ABCD at cycles 2-4; cycle 5: instruction=0, done=1.
  - busy is high for exactly cycles 1-4; pc=0 then 1.
- Looping: same program with loop_count=3.
  - Required: the pattern [01, CD, CD, CD] repeats 3 times with no gap at cycles 1-12; done=1 at cycle 13 only.
  - loop_count=0 behaves identically to loop_count=1.
- Abort: basic program with H1=9; assert abort at cycle 3.
  - Required: at cycle 4 instruction=0, busy=0, and done never pulses.
  - A new start at cycle 6 restarts from entry 0 at cycle 7.
- Error and illegal writes:
  - start with prog_len=0 -> err=1 for one cycle, busy stays 0. Repeat with prog_len=DEPTH+1 -> same result.
  - prog_we to addr 1 with data 0x00FFFFFF during RUN -> ignored; a rerun still issues 0x00ABCD.
- Reset mid-run: drive rst=0 asynchronously during cycle 3 of the basic run.
  - Required: instruction=0, busy=0, pc=0 immediately, before the next clock edge.
  - After release, the block stays in IDLE until start.
- Full depth: prog_len=DEPTH with H=0 for all entries and mem[k]=k.
  - Required: instruction=k and pc=k at cycle k+1 for k=0..DEPTH-1; done at cycle DEPTH+1.
